reg_file: RTL and testbench

- Architectural register file with per-register rename tags.
- Terminates the ROB's commit/rename interface: the ROB writes committed values and records new producer tags, and the Decoder queries two source operands per cycle.
- Sits between the ROB and the Decoder/RS. The ROB's `rob_clear` drops all outstanding renames after a mispredict.

---
 rtl/reg_file.sv | 80 ++++++++
 tb/tb_reg_file.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: architectural register file with per-register rename tags and commit bypass
module reg_file #(
  parameter int ROB_SIZE_BIT = 5,
  parameter int XLEN         = 32,
  parameter int REG_NUM      = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    rob_clear,
  input  logic                    is_update_val,
  input  logic [4:0]              update_val_id,
  input  logic [ROB_SIZE_BIT-1:0] update_val_dep,
  input  logic [XLEN-1:0]         update_val,
  input  logic                    is_update_dep,
  input  logic [4:0]              update_dep_id,
  input  logic [ROB_SIZE_BIT-1:0] update_dep,
  input  logic [4:0]              qry1_reg,
  output logic [XLEN-1:0]         qry1_val,
  output logic                    qry1_has_dep,
  output logic [ROB_SIZE_BIT-1:0] qry1_dep,
  input  logic [4:0]              qry2_reg,
  output logic [XLEN-1:0]         qry2_val,
  output logic                    qry2_has_dep,
  output logic [ROB_SIZE_BIT-1:0] qry2_dep
);
  logic [XLEN-1:0]         val  [REG_NUM];
  logic [ROB_SIZE_BIT-1:0] dep  [REG_NUM];
  logic [REG_NUM-1:0]      busy;
  logic commit, rename;
  assign commit = is_update_val && update_val_id != '0;
  assign rename = is_update_dep && update_dep_id != '0;
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        val[i] <= '0;
        dep[i] <= '0;
      end
    end else if (rdy_in) begin
      if (rob_clear) begin
        busy <= '0;
        for (int i = 0; i < REG_NUM; i++) dep[i] <= '0;
      end else begin
        if (commit) begin
          val[update_val_id] <= update_val;
          // a tag mismatch means a younger producer still owns the register
          if (busy[update_val_id] && dep[update_val_id] == update_val_dep &&
              !(rename && update_dep_id == update_val_id))
            busy[update_val_id] <= 1'b0;
        end
        if (rename) begin
          busy[update_dep_id] <= 1'b1;
          dep[update_dep_id]  <= update_dep;
        end
      end
    end
  end
  logic [4:0]              q_reg [2];
  logic [XLEN-1:0]         q_val [2];
  logic                    q_hd  [2];
  logic [ROB_SIZE_BIT-1:0] q_dep [2];
  assign q_reg[0] = qry1_reg;
  assign q_reg[1] = qry2_reg;
  for (genvar i = 0; i < 2; i++) begin : g_q
    logic zero, byp;
    assign zero     = q_reg[i] == '0;
    assign byp      = is_update_val && !rob_clear && update_val_id == q_reg[i] &&
                      busy[q_reg[i]] && dep[q_reg[i]] == update_val_dep;
    assign q_val[i] = zero ? '0 : byp ? update_val : val[q_reg[i]];
    assign q_hd[i]  = !zero && !byp && busy[q_reg[i]];
    assign q_dep[i] = q_hd[i] ? dep[q_reg[i]] : '0;
  end
  assign qry1_val     = q_val[0];
  assign qry1_has_dep = q_hd[0];
  assign qry1_dep     = q_dep[0];
  assign qry2_val     = q_val[1];
  assign qry2_has_dep = q_hd[1];
  assign qry2_dep     = q_dep[1];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file, directed scenarios then randomized traffic against a model
module tb_reg_file;
  logic        clk_in = 0, rst_in, rdy_in, rob_clear;
  logic        is_update_val, is_update_dep;
  logic [4:0]  update_val_id, update_val_dep, update_dep_id, update_dep;
  logic [31:0] update_val;
  logic [4:0]  qry1_reg, qry2_reg, qry1_dep, qry2_dep;
  logic [31:0] qry1_val, qry2_val;
  logic        qry1_has_dep, qry2_has_dep;
  int vectors = 0, errors = 0;
  always #5 clk_in = ~clk_in;
  reg_file dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .is_update_val(is_update_val), .update_val_id(update_val_id),
    .update_val_dep(update_val_dep), .update_val(update_val),
    .is_update_dep(is_update_dep), .update_dep_id(update_dep_id), .update_dep(update_dep),
    .qry1_reg(qry1_reg), .qry1_val(qry1_val), .qry1_has_dep(qry1_has_dep), .qry1_dep(qry1_dep),
    .qry2_reg(qry2_reg), .qry2_val(qry2_val), .qry2_has_dep(qry2_has_dep), .qry2_dep(qry2_dep)
  );
  typedef struct {
    string       tag;
    int          port;
    logic [31:0] v;
    logic        hd;
    logic [4:0]  d;
  } exp_t;
  exp_t sb[$];
  logic [31:0] mv [32];
  logic [4:0]  md [32];
  logic        mb [32];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic expq(input string tag, input int port, input logic [31:0] v,
                      input logic hd, input logic [4:0] d);
    sb.push_back('{tag, port, v, hd, d});
  endtask
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_val"}, e.port == 1 ? qry1_val : qry2_val, e.v);
      chk({e.tag, "_hd"},  e.port == 1 ? qry1_has_dep : qry2_has_dep, e.hd);
      chk({e.tag, "_dep"}, e.port == 1 ? qry1_dep : qry2_dep, e.d);
    end
  endtask
  task automatic model_update();
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) begin mv[i] = 0; md[i] = 0; mb[i] = 0; end
    end else if (rdy_in) begin
      if (rob_clear) begin
        for (int i = 0; i < 32; i++) begin md[i] = 0; mb[i] = 0; end
      end else begin
        if (is_update_val && update_val_id != 0) begin
          mv[update_val_id] = update_val;
          if (mb[update_val_id] && md[update_val_id] == update_val_dep &&
              !(is_update_dep && update_dep_id == update_val_id))
            mb[update_val_id] = 0;
        end
        if (is_update_dep && update_dep_id != 0) begin
          mb[update_dep_id] = 1;
          md[update_dep_id] = update_dep;
        end
      end
    end
  endtask
  task automatic model_exp(input string tag, input int port, input logic [4:0] r);
    logic byp;
    byp = is_update_val && !rob_clear && update_val_id == r && mb[r] && md[r] == update_val_dep;
    if (r == 0) expq(tag, port, 0, 0, 0);
    else if (byp) expq(tag, port, update_val, 0, 0);
    else expq(tag, port, mv[r], mb[r], mb[r] ? md[r] : 5'd0);
  endtask
  task automatic step();
    #1 drain();
    @(posedge clk_in);
    model_update();
    @(negedge clk_in);
    {rob_clear, is_update_val, is_update_dep} = '0;
  endtask
  task automatic cmt(input logic [4:0] r, input logic [31:0] v, input logic [4:0] t);
    is_update_val = 1; update_val_id = r; update_val = v; update_val_dep = t;
  endtask
  task automatic ren(input logic [4:0] r, input logic [4:0] t);
    is_update_dep = 1; update_dep_id = r; update_dep = t;
  endtask
  initial begin
    {rob_clear, is_update_val, is_update_dep} = '0;
    {update_val_id, update_val_dep, update_dep_id, update_dep, update_val} = '0;
    rst_in = 0; rdy_in = 1; qry1_reg = 5; qry2_reg = 0;
    @(negedge clk_in);
    step();
    rst_in = 1;
    expq("rst_x5", 1, 0, 0, 0); expq("rst_x0", 2, 0, 0, 0);
    ren(0, 3);
    step();
    expq("x0_ren", 2, 0, 0, 0);
    ren(5, 7);
    step();
    expq("x5_busy", 1, 0, 1, 7);
    step();
    cmt(5, 32'hDEADBEEF, 7);
    expq("x5_byp", 1, 32'hDEADBEEF, 0, 0);
    step();
    expq("x5_done", 1, 32'hDEADBEEF, 0, 0);
    ren(6, 2);
    step();
    ren(6, 9);
    step();
    qry2_reg = 6; cmt(6, 32'h11, 2);
    expq("x6_stale", 2, 0, 1, 9);
    step();
    expq("x6_young", 2, 32'h11, 1, 9);
    ren(8, 4);
    step();
    qry1_reg = 8; cmt(8, 32'h55, 4); ren(8, 12);
    expq("x8_byp", 1, 32'h55, 0, 0);
    step();
    expq("x8_ren", 1, 32'h55, 1, 12);
    ren(1, 1); step();
    ren(2, 2); step();
    ren(3, 3); step();
    qry1_reg = 1; qry2_reg = 4; rob_clear = 1; cmt(1, 32'h99, 1); ren(4, 5);
    expq("clr_nobyp", 1, 0, 1, 1);
    step();
    expq("clr_x1", 1, 0, 0, 0); expq("clr_x4", 2, 0, 0, 0);
    step();
    qry1_reg = 2; qry2_reg = 3;
    expq("clr_x2", 1, 0, 0, 0); expq("clr_x3", 2, 0, 0, 0);
    step();
    qry1_reg = 5; qry2_reg = 8;
    expq("clr_keep5", 1, 32'hDEADBEEF, 0, 0); expq("clr_keep8", 2, 32'h55, 0, 0);
    step();
    rdy_in = 0; qry1_reg = 10; qry2_reg = 7; ren(10, 6); cmt(7, 32'h77, 0);
    step();
    expq("stall_x10", 1, 0, 0, 0); expq("stall_x7", 2, 0, 0, 0);
    step();
    rst_in = 0; qry1_reg = 5; qry2_reg = 6;
    step();
    rst_in = 1; rdy_in = 1;
    expq("rst2_x5", 1, 0, 0, 0); expq("rst2_x6", 2, 0, 0, 0);
    step();
    for (int n = 0; n < 400; n++) begin
      rst_in    = $urandom_range(0, 99) != 0;
      rdy_in    = $urandom_range(0, 9) != 0;
      rob_clear = $urandom_range(0, 19) == 0;
      is_update_dep = $urandom_range(0, 1);
      update_dep_id = 5'($urandom_range(0, 7));
      update_dep    = 5'($urandom);
      is_update_val  = $urandom_range(0, 1);
      update_val_id  = 5'($urandom_range(0, 7));
      update_val     = $urandom;
      update_val_dep = $urandom_range(0, 2) != 0 ? md[update_val_id] : 5'($urandom);
      qry1_reg = $urandom_range(0, 2) == 0 ? update_val_id : 5'($urandom_range(0, 7));
      qry2_reg = 5'($urandom_range(0, 7));
      model_exp("rnd_q1", 1, qry1_reg);
      model_exp("rnd_q2", 2, qry2_reg);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
